dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit memory words (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait states inserted before each response (0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 req_valid  input  1  SHALL indicate the initiator presents a request.
REQ-006 req_ready  output  1  SHALL indicate the responder can accept a request.
REQ-007 req_we  input  1  SHALL select a write (1) or read (0).
REQ-008 req_addr  input  32  SHALL carry the byte address.
REQ-009 req_wd  input  32  SHALL carry the write data.
REQ-010 rsp_valid  output  1  SHALL indicate a response is presented.
REQ-011 rsp_ready  input  1  SHALL indicate the initiator accepts the response.
REQ-012 rsp_rd  output  32  SHALL carry the read data.
REQ-013 rsp_err  output  1  SHALL flag a misaligned or out-of-range access.
REQ-014 dbg_addr  input  log2(DEPTH)  SHALL be the word index for the debug read port.
REQ-015 dbg_rd  output  32  SHALL return the word at dbg_addr combinationally.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted when req_valid and req_ready are both 1; at that point we, addr and wd SHALL be latched and the wait counter loaded with WAIT_CYCLES.
REQ-018 On acceptance the FSM SHALL go IDLE->RESP if WAIT_CYCLES=0, otherwise IDLE->WAIT.
REQ-019 In WAIT the counter SHALL decrement every cycle; when the counter equals 1 the FSM SHALL go WAIT->RESP.
REQ-020 rsp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 The write commit and the read-data capture SHALL occur on the edge that enters RESP; a read of the just-written word in the next request SHALL return the new value.
REQ-022 Word index SHALL be addr[log2(DEPTH)+1:2]; an access SHALL be an error if addr[1:0]!=0 or addr[31:log2(DEPTH)+2]!=0.
REQ-023 An error access SHALL NOT write memory; it SHALL respond with rsp_err=1 and rsp_rd=0.
REQ-024 A good read SHALL respond with rsp_rd=mem[index], rsp_err=0; a good write SHALL respond with rsp_rd=0, rsp_err=0.
REQ-025 In RESP, rsp_valid, rsp_rd and rsp_err SHALL hold stable until rsp_ready=1; on that edge the FSM SHALL go RESP->IDLE.
REQ-026 Only one request SHALL be outstanding; a new request cannot be accepted in the cycle its predecessor's response completes (minimum one IDLE cycle between responses).
REQ-027 req_valid while not in IDLE SHALL be ignored (no latch, no side effect).
REQ-028 dbg_rd SHALL reflect a committed write from the cycle after the commit edge.

Reset
REQ-029 When rst=1 on an edge the FSM SHALL enter IDLE, and rsp_valid, rsp_rd, rsp_err and the wait counter SHALL be 0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 A reset during WAIT SHALL abandon the request with no write committed; a reset during RESP SHALL drop the response, and the write already committed SHALL remain.

Structure
REQ-032 A shared package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the WAIT_CYCLES default constant.
REQ-033 The storage SHALL be a sub-module dmem_ram: DEPTH x 32, one synchronous write port and two asynchronous read ports (access and debug).

Verification
REQ-034 Write then read: write 0xDEADBEEF to addr 0x10 with rsp_ready=1 -> rsp_valid at acceptance+3, err=0; the following read of 0x10 -> rsp_rd=0xDEADBEEF.
REQ-035 Misaligned access: write to addr 0x13 -> rsp_err=1, rsp_rd=0; dbg_addr=4 returns the prior value, unchanged.
REQ-036 Out of range (DEPTH=64): read addr 0x100 -> rsp_err=1, rsp_rd=0.
REQ-037 Backpressure: read with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rd and rsp_err stable throughout and req_ready=0; rsp_ready=1 -> IDLE on the next edge.
REQ-038 WAIT_CYCLES=0: accept at edge N -> rsp_valid=1 after edge N+1.
REQ-039 Reset mid-WAIT: write 0x12345678 to addr 0x20 and assert rst in the cycle after acceptance -> rsp_valid never asserts, req_ready=1 after reset, and dbg_addr=8 returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Default number of wait states inserted before each response.
   localparam int WAIT_CYCLES_DEF = 2;

   // Width of the wait-state counter (covers 0..15).
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 storage: one synchronous write port, two asynchronous read ports.
module dmem_ram #(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] a_addr,
   output logic [31:0]   a_rd,
   input  logic [AW-1:0] b_addr,
   output logic [31:0]   b_rd
);

   logic [31:0] mem [DEPTH];

   // Write port; contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign a_rd = mem[a_addr];
   assign b_rd = mem[b_addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder with programmable wait states,
// address checking and a combinational debug read port.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter  int DEPTH       = 64,
   parameter  int WAIT_CYCLES = WAIT_CYCLES_DEF,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wd,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rd,
   output logic          rsp_err,
   input  logic [AW-1:0] dbg_addr,
   output logic [31:0]   dbg_rd
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wd_q, wd_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rd_q, rsp_rd_d;
   logic             rsp_err_q, rsp_err_d;

   logic             cur_we;
   logic [31:0]      cur_addr;
   logic [31:0]      cur_wd;
   logic             cur_err;
   logic [AW-1:0]    cur_idx;
   logic             enter_resp;
   logic             ram_we;
   logic [31:0]      ram_rd;

   // Select the transaction being serviced. With zero wait states RESP is
   // entered on the acceptance edge itself, so the live request fields are
   // used in IDLE and the latched copies otherwise.
   always_comb begin
      cur_we   = we_q;
      cur_addr = addr_q;
      cur_wd   = wd_q;
      if (state_q == IDLE) begin
         cur_we   = req_we;
         cur_addr = req_addr;
         cur_wd   = req_wd;
      end
      cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (AW + 2)) != 32'd0);
      cur_idx = cur_addr[AW+1:2];
   end

   // Next state, request latching and response capture. The response flag is
   // registered one cycle after RESP is entered, which gives the
   // WAIT_CYCLES+1 latency while commit/capture happen on the RESP entry edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wd_d        = wd_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rd_d    = rsp_rd_q;
      rsp_err_d   = rsp_err_q;
      enter_resp  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d   = req_we;
               addr_d = req_addr;
               wd_d   = req_wd;
               cnt_d  = CNT_INIT;
               if (WAIT_CYCLES == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_rd_d    = 32'd0;
               rsp_err_d   = 1'b0;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (enter_resp) begin
         rsp_err_d = cur_err;
         rsp_rd_d  = (cur_err || cur_we) ? 32'd0 : ram_rd;
      end
   end

   assign ram_we = enter_resp && cur_we && !cur_err;

   // State and response registers; memory is not touched by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wd_q        <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wd_q        <= wd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   dmem_ram #(.DEPTH(DEPTH)) u_ram (
      .clk    (clk),
      .we     (ram_we),
      .waddr  (cur_idx),
      .wdata  (cur_wd),
      .a_addr (cur_idx),
      .a_rd   (ram_rd),
      .b_addr (dbg_addr),
      .b_rd   (dbg_rd)
   );

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rd    = rsp_rd_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: random traffic against a word-array reference model,
// plus directed backpressure, reset-in-WAIT and zero-wait-state cases.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int W     = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = 32'd0, req_wd = 32'd0;
   logic [5:0]  dbg_addr = 6'd0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rd, dbg_rd;

   logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
   logic [31:0] req_addr0 = 32'd0, req_wd0 = 32'd0;
   logic [5:0]  dbg_addr0 = 6'd0;
   logic        req_ready0, rsp_valid0, rsp_err0;
   logic [31:0] rsp_rd0, dbg_rd0;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wd(req_wd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
      .rsp_err(rsp_err), .dbg_addr(dbg_addr), .dbg_rd(dbg_rd)
   );

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we0), .req_addr(req_addr0), .req_wd(req_wd0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rd(rsp_rd0),
      .rsp_err(rsp_err0), .dbg_addr(dbg_addr0), .dbg_rd(dbg_rd0)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rd;
      bit          err;
      int          acc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] model [DEPTH];
   int          total = 0;
   int          bad   = 0;
   int          mode  = 0;   // rsp_ready: 0 random, 1 held low, 2 held high
   bit          seen  = 1'b0;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Present a request; while the responder is busy, the bus carries
   // unrelated write traffic that must be ignored.
   task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd, input bit push);
      int n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         req_we   = 1'b1;
         req_addr = $urandom & 32'h0000_00FC;
         req_wd   = $urandom;
         if (n > 100) begin
            chk(1'b0, "req_ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
         end
      end
      req_we   = we;
      req_addr = addr;
      req_wd   = wd;
      if (push) begin
         exp_t e;
         e.acc = cyc + 1;
         e.err = (addr % 4 != 0) || (addr >= DEPTH * 4);
         e.rd  = 32'd0;
         if (!e.err) begin
            if (we) model[addr / 4] = wd;
            else    e.rd = model[addr / 4];
         end
         q.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wd    = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk(1'b0, "drain_timeout", q.size(), 32'd0);
      @(negedge clk);
   endtask

   task automatic dbg_chk(input int idx, input string nm);
      dbg_addr = 6'(idx);
      #1;
      chk(dbg_rd === model[idx], nm, dbg_rd, model[idx]);
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      logic [31:0] a = {24'd0, 6'($urandom), 2'b00};
      if (r == 7) a = a | 32'($urandom_range(1, 3));
      else if (r == 8) a = $urandom | 32'h0000_0100;
      else if (r == 9) a = a | 32'h8000_0000;
      return a;
   endfunction

   // rsp_ready driver, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (mode)
            0:       rsp_ready = 1'($urandom);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compare every presented response cycle against the queue head.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (q.size() == 0) begin
            chk(1'b0, "unexpected_rsp", rsp_rd, 32'd0);
         end else begin
            if (!seen) begin
               chk(cyc == q[0].acc + W + 1, "rsp_latency", cyc, q[0].acc + W + 1);
               seen = 1'b1;
            end
            chk(rsp_rd === q[0].rd, "rsp_rd", rsp_rd, q[0].rd);
            chk(rsp_err === q[0].err, "rsp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
            chk(req_ready == 1'b0, "busy_req_ready", {31'd0, req_ready}, 32'd0);
            if (rsp_ready) begin
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(rsp_valid == 1'b0, "rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk(req_ready == 1'b1, "rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk(rsp_rd == 32'd0, "rst_rsp_rd", rsp_rd, 32'd0);
      chk(rsp_err == 1'b0, "rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk(rsp_valid0 == 1'b0, "rst_rsp_valid0", {31'd0, rsp_valid0}, 32'd0);
      rst = 1'b0;

      // Fill every word so the model is fully defined.
      for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1);
      drain();

      // Write then read back; misaligned write; out-of-range read.
      issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
      issue(1'b0, 32'h10, 32'd0, 1'b1);
      issue(1'b1, 32'h13, 32'hCAFEF00D, 1'b1);
      issue(1'b0, 32'h100, 32'd0, 1'b1);
      drain();
      dbg_chk(4, "dbg_after_misaligned");
      chk(dbg_rd === 32'hDEADBEEF, "dbg_word4_value", dbg_rd, 32'hDEADBEEF);

      // Random traffic.
      for (int i = 0; i < 150; i++) issue(1'($urandom), rand_addr(), $urandom, 1'b1);
      drain();
      for (int i = 0; i < DEPTH; i += 9) dbg_chk(i, "dbg_after_random");

      // Backpressure: response held for five cycles, then released.
      mode = 1;
      @(posedge clk); #2;
      issue(1'b0, 32'h10, 32'd0, 1'b1);
      begin
         int n = 0;
         while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk(rsp_valid == 1'b1, "bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      end
      repeat (5) begin
         @(negedge clk);
         chk(rsp_valid == 1'b1, "bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      end
      mode = 2;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk(req_ready == 1'b1, "bp_release_ready", {31'd0, req_ready}, 32'd1);
      chk(rsp_valid == 1'b0, "bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      chk(q.size() == 0, "bp_queue_empty", q.size(), 32'd0);
      mode = 0;

      // Reset in the cycle after acceptance abandons the write.
      drain();
      issue(1'b1, 32'h20, 32'h12345678, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk(req_ready == 1'b1, "rstwait_req_ready", {31'd0, req_ready}, 32'd1);
      chk(rsp_valid == 1'b0, "rstwait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (6) @(negedge clk);
      dbg_chk(8, "rstwait_dbg_old_value");

      // Zero wait states: accept at edge N, response visible after edge N+1.
      @(negedge clk);
      req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wd0 = 32'hA5A5_5A5A;
      chk(req_ready0 == 1'b1, "w0_ready", {31'd0, req_ready0}, 32'd1);
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      @(negedge clk);
      chk(rsp_valid0 == 1'b0, "w0_not_early", {31'd0, rsp_valid0}, 32'd0);
      @(negedge clk);
      chk(rsp_valid0 == 1'b1, "w0_wr_valid", {31'd0, rsp_valid0}, 32'd1);
      chk(rsp_rd0 == 32'd0 && rsp_err0 == 1'b0, "w0_wr_rsp", rsp_rd0, 32'd0);
      @(negedge clk);
      chk(req_ready0 == 1'b1, "w0_back_idle", {31'd0, req_ready0}, 32'd1);
      dbg_addr0 = 6'd2;
      #1;
      chk(dbg_rd0 == 32'hA5A5_5A5A, "w0_dbg", dbg_rd0, 32'hA5A5_5A5A);
      @(negedge clk);
      req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h8;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk(rsp_valid0 == 1'b1, "w0_rd_valid", {31'd0, rsp_valid0}, 32'd1);
      chk(rsp_rd0 == 32'hA5A5_5A5A, "w0_rd_data", rsp_rd0, 32'hA5A5_5A5A);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
